// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared SDRAM definitions used by the init, refresh, write and read blocks.
//   - Command encodings on {cs_n, ras_n, cas_n, we_n}
//   - Bus values driven while a block is not issuing a command
//   - Address field widths of the {bank, row, col} client address
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_BURST_STOP   = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  localparam int BA_W  = 2;
  localparam int ROW_W = 13;
  localparam int COL_W = 9;

  localparam logic [BA_W-1:0]  IDLE_BA   = 2'b11;
  localparam logic [ROW_W-1:0] IDLE_ADDR = 13'h1fff;

  // A10 high selects all banks for PRECHARGE.
  localparam logic [ROW_W-1:0] PRECH_ALL_ADDR = 13'h0400;

endpackage

// File: rtl/sdram_read_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_read_ctrl
// Read-side responder to the SDRAM arbiter. Requests the bus when the client
// wants a read, and on grant runs one ACTIVE / READ / BURST_STOP / PRECHARGE
// sequence on a single row. Returning sdram_dq words are pushed to the read FIFO.
//
// Ports:
//   i_sysclk, i_sysrst_n   clock, asynchronous active-low reset
//   i_init_done            SDRAM initialisation complete
//   i_rd_en                client wants a read burst (level)
//   i_rd_addr[23:0]        {bank[23:22], row[21:9], col[8:0]}
//   i_rd_burst_len[9:0]    words per burst (0 -> 1, > PAGE_LEN -> PAGE_LEN)
//   i_read_start           arbiter grant (level)
//   i_rd_sdram_data[15:0]  sdram_dq as seen at the pins
//   o_rd_request           request to arbiter (registered)
//   o_rd_cmd/ba/addr       command, bank and address toward the arbiter mux
//   o_rd_done              one-cycle completion pulse
//   o_rd_fifo_wr_en/data   read-FIFO write strobe and captured word
//
// Arbiter handshake: o_rd_request is raised only in IDLE. The grant
// i_read_start is sampled only in IDLE; once the sequence starts it runs to
// completion whatever the grant does, and o_rd_done pulses once at the end.
// The arbiter is expected to drop the grant on seeing o_rd_done.
// -----------------------------------------------------------------------------
module sdram_read_ctrl
  import sdram_pkg::*;
#(
  parameter int TRCD_CLK = 2,
  parameter int CL       = 3,
  parameter int TRP_CLK  = 2,
  parameter int PAGE_LEN = 512
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst_n,
  input  logic        i_init_done,
  input  logic        i_rd_en,
  input  logic [23:0] i_rd_addr,
  input  logic [9:0]  i_rd_burst_len,
  input  logic        i_read_start,
  input  logic [15:0] i_rd_sdram_data,
  output logic        o_rd_request,
  output logic [3:0]  o_rd_cmd,
  output logic [1:0]  o_rd_ba,
  output logic [12:0] o_rd_addr,
  output logic        o_rd_done,
  output logic        o_rd_fifo_wr_en,
  output logic [15:0] o_rd_fifo_wr_data
);

  localparam int CW = $clog2(PAGE_LEN + CL + TRP_CLK + TRCD_CLK) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ACTIVE, S_TRCD, S_READ, S_RD_DATA, S_PRECH, S_TRP, S_DONE
  } rd_state_t;

  rd_state_t          r_state;
  logic [CW-1:0]      r_cnt;      // cycles since the ACTIVE cycle
  logic [23:0]        r_addr;
  logic [9:0]         r_bl;
  logic               r_req;
  logic [3:0]         r_cmd;
  logic [BA_W-1:0]    r_ba;
  logic [ROW_W-1:0]   r_a;
  logic               r_done;
  logic               r_wr_en;
  logic [15:0]        r_dq;       // pin data, registered every cycle
  logic [15:0]        r_hold;     // last word written to the FIFO

  // Phase boundaries, all relative to the ACTIVE cycle (count 0).
  logic [CW-1:0] w_nxt, w_bl, w_r, w_rc, w_bs, w_p, w_d;
  assign w_nxt = r_cnt + CW'(1);
  assign w_bl  = CW'(r_bl);
  assign w_r   = CW'(TRCD_CLK);         // READ
  assign w_bs  = w_r + w_bl;            // BURST_STOP
  assign w_rc  = w_r + CW'(CL);         // first data word at the pins
  assign w_p   = w_rc + w_bl;           // PRECHARGE, also the last strobe
  assign w_d   = w_p + CW'(TRP_CLK);    // done pulse

  function automatic logic [9:0] clamp_bl(input logic [9:0] bl);
    if (bl == 10'd0)               return 10'd1;
    else if (int'(bl) > PAGE_LEN)  return 10'(PAGE_LEN);
    else                           return bl;
  endfunction

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_bl    <= '0;
      r_req   <= 1'b0;
      r_cmd   <= CMD_NOP;
      r_ba    <= IDLE_BA;
      r_a     <= IDLE_ADDR;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;
      r_dq    <= '0;
      r_hold  <= '0;
    end else begin
      r_dq <= i_rd_sdram_data;
      if (r_wr_en) r_hold <= r_dq;

      // Idle bus values unless a state below issues a command.
      r_req   <= 1'b0;
      r_cmd   <= CMD_NOP;
      r_ba    <= IDLE_BA;
      r_a     <= IDLE_ADDR;
      r_done  <= 1'b0;
      r_wr_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_init_done && i_read_start) begin
            r_state <= S_ACTIVE;
            r_addr  <= i_rd_addr;
            r_bl    <= clamp_bl(i_rd_burst_len);
            r_cmd   <= CMD_ACTIVE;
            r_ba    <= i_rd_addr[23:22];
            r_a     <= i_rd_addr[21:9];
          end else begin
            r_req <= i_init_done && i_rd_en;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_cnt <= w_nxt;
          if (w_nxt < w_r) begin
            r_state <= S_TRCD;
          end else if (w_nxt == w_r) begin
            r_state <= S_READ;
            r_cmd   <= CMD_READ;
            r_ba    <= r_addr[23:22];
            r_a     <= {{(ROW_W-COL_W){1'b0}}, r_addr[8:0]};
          end else if (w_nxt < w_p) begin
            r_state <= S_RD_DATA;
          end else if (w_nxt == w_p) begin
            r_state <= S_PRECH;
            r_cmd   <= CMD_PRECHARGE;
            r_ba    <= r_addr[23:22];
            r_a     <= PRECH_ALL_ADDR;
          end else if (w_nxt < w_d) begin
            r_state <= S_TRP;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
          // BURST_STOP lands strictly between READ and PRECHARGE since CL >= 2.
          if (w_nxt == w_bs) r_cmd <= CMD_BURST_STOP;
          // A word seen at the pins in cycle t is strobed in cycle t+1.
          r_wr_en <= (w_nxt > w_rc) && (w_nxt <= w_p);
        end
      endcase
    end
  end

  assign o_rd_request      = r_req;
  assign o_rd_cmd          = r_cmd;
  assign o_rd_ba           = r_ba;
  assign o_rd_addr         = r_a;
  assign o_rd_done         = r_done;
  assign o_rd_fifo_wr_en   = r_wr_en;
  assign o_rd_fifo_wr_data = r_wr_en ? r_dq : r_hold;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdram_read_ctrl
// Directed bench for sdram_read_ctrl with default parameters. The bench plays
// the arbiter and the SDRAM device: it grants on request, drives a row model
// onto sdram_dq at the CAS-latency window, and queues the words it drove.
// -----------------------------------------------------------------------------
module tb_sdram_read_ctrl;
  import sdram_pkg::*;

  localparam int TRCD = 2;
  localparam int CLAT = 3;
  localparam int TRP  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        rd_en = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [9:0]  burst_len = '0;
  logic        read_start = 1'b0;
  logic [15:0] dq = '0;

  logic        rd_request;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_addr_o;
  logic        rd_done;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;

  sdram_read_ctrl dut (
    .i_sysclk          (clk),
    .i_sysrst_n        (rst_n),
    .i_init_done       (init_done),
    .i_rd_en           (rd_en),
    .i_rd_addr         (rd_addr),
    .i_rd_burst_len    (burst_len),
    .i_read_start      (read_start),
    .i_rd_sdram_data   (dq),
    .o_rd_request      (rd_request),
    .o_rd_cmd          (rd_cmd),
    .o_rd_ba           (rd_ba),
    .o_rd_addr         (rd_addr_o),
    .o_rd_done         (rd_done),
    .o_rd_fifo_wr_en   (fifo_wr_en),
    .o_rd_fifo_wr_data (fifo_wr_data)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Row model: each word encodes its bank, low row bits and wrapped column.
  function automatic logic [15:0] model_word(input logic [1:0] ba, input logic [12:0] row,
                                             input int col);
    logic [8:0] c;
    c = 9'(col & 511);
    return {ba, row[4:0], c};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " req"},     32'(rd_request),   32'd0);
    check({tag, " cmd"},     32'(rd_cmd),       32'(CMD_NOP));
    check({tag, " ba"},      32'(rd_ba),        32'(IDLE_BA));
    check({tag, " addr"},    32'(rd_addr_o),    32'(IDLE_ADDR));
    check({tag, " done"},    32'(rd_done),      32'd0);
    check({tag, " wr_en"},   32'(fifo_wr_en),   32'd0);
    check({tag, " wr_data"}, 32'(fifo_wr_data), 32'd0);
  endtask

  // Called on a falling edge; returns on the falling edge where request is seen.
  task automatic wait_request(input string tag);
    int t;
    t = 0;
    while (rd_request !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, " req_seen"}, 32'(rd_request), 32'd1);
  endtask

  // One granted burst. eff is the hand-clamped burst length; drop_at < 0 keeps
  // the grant until done.
  task automatic run_burst(input string tag, input logic [23:0] addr, input logic [9:0] len,
                           input int eff, input int drop_at);
    int a_pos, r_pos, bs_pos, p_pos, d_pos, req_pos;
    int n_done, n_wr, n_bad_idle, n_req_busy, last;
    logic [15:0] w, last_w;
    a_pos = -1; r_pos = -1; bs_pos = -1; p_pos = -1; d_pos = -1; req_pos = -1;
    n_done = 0; n_wr = 0; n_bad_idle = 0; n_req_busy = 0;
    last_w = '0;
    last = TRCD + CLAT + eff + TRP;
    rd_addr   = addr;
    burst_len = len;
    rd_en     = 1'b1;
    wait_request(tag);
    read_start = 1'b1;
    for (int k = 0; k <= last + 4; k++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        n_wr++;
        if (exp_q.size() > 0) check({tag, " data"}, 32'(fifo_wr_data), 32'(exp_q.pop_front()));
      end
      if (k >= TRCD + CLAT && k < TRCD + CLAT + eff) begin
        w = model_word(addr[23:22], addr[21:9], int'(addr[8:0]) + k - (TRCD + CLAT));
        dq = w;
        last_w = w;
        exp_q.push_back(w);
      end else begin
        dq = 16'($urandom);
      end
      case (rd_cmd)
        CMD_ACTIVE: begin
          a_pos = k;
          check({tag, " act_ba"},   32'(rd_ba),     32'(addr[23:22]));
          check({tag, " act_addr"}, 32'(rd_addr_o), 32'(addr[21:9]));
        end
        CMD_READ: begin
          r_pos = k;
          check({tag, " rd_ba"},   32'(rd_ba),     32'(addr[23:22]));
          check({tag, " rd_addr"}, 32'(rd_addr_o), {23'd0, addr[8:0]});
        end
        CMD_BURST_STOP: bs_pos = k;
        CMD_PRECHARGE: begin
          p_pos = k;
          check({tag, " pre_ba"},   32'(rd_ba),     32'(addr[23:22]));
          check({tag, " pre_addr"}, 32'(rd_addr_o), 32'h0400);
        end
        CMD_NOP: if (rd_ba !== IDLE_BA || rd_addr_o !== IDLE_ADDR) n_bad_idle++;
        default: n_bad_idle++;
      endcase
      if (rd_done) begin
        n_done++;
        d_pos = k;
        read_start = 1'b0;
      end
      if (drop_at >= 0 && k == drop_at) read_start = 1'b0;
      if (k <= last && rd_request) n_req_busy++;
      if (k > last && rd_request && req_pos < 0) req_pos = k;
    end
    read_start = 1'b0;
    check({tag, " act_pos"},   32'(a_pos),  32'd0);
    check({tag, " read_pos"},  32'(r_pos),  32'(TRCD));
    check({tag, " bstop_pos"}, 32'(bs_pos), 32'(TRCD + eff));
    check({tag, " pre_pos"},   32'(p_pos),  32'(TRCD + CLAT + eff));
    check({tag, " done_pos"},  32'(d_pos),  32'(last));
    check({tag, " done_cnt"},  32'(n_done), 32'd1);
    check({tag, " wr_cnt"},    32'(n_wr),   32'(eff));
    check({tag, " q_left"},    32'(exp_q.size()), 32'd0);
    check({tag, " idle_bus"},  32'(n_bad_idle), 32'd0);
    check({tag, " req_busy"},  32'(n_req_busy), 32'd0);
    check({tag, " req_again"}, 32'(req_pos), 32'(last + 2));
    check({tag, " data_hold"}, 32'(fifo_wr_data), 32'(last_w));
    exp_q.delete();
  endtask

  task automatic reset_mid_burst();
    int n_bad;
    rd_addr   = {2'b00, 13'h0042, 9'h020};
    burst_len = 10'd8;
    rd_en     = 1'b1;
    wait_request("rst");
    read_start = 1'b1;
    for (int k = 0; k <= TRCD + 5; k++) begin
      @(negedge clk);
      dq = 16'($urandom);
    end
    check("rst pre_wr_en", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst async");
    read_start = 1'b0;
    n_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (fifo_wr_en || rd_cmd !== CMD_NOP || rd_done || rd_request) n_bad++;
    end
    check("rst held_quiet", 32'(n_bad), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst req_resume", 32'(rd_request), 32'd1);
  endtask

  initial begin : main
    int n_bad;
    rd_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Held out of service until init completes.
    n_bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rd_request || rd_cmd !== CMD_NOP) n_bad++;
    end
    check("init_wait quiet", 32'(n_bad), 32'd0);
    init_done = 1'b1;
    @(negedge clk);
    check("init_wait req_rise", 32'(rd_request), 32'd1);

    run_burst("bl10",   {2'b01, 13'h0123, 9'h010}, 10'd10,  10,  -1);
    run_burst("bl0",    {2'b10, 13'h0777, 9'h0ff}, 10'd0,   1,   -1);
    run_burst("bl600",  {2'b10, 13'h0abc, 9'h1f0}, 10'd600, 512, -1);
    run_burst("drop",   {2'b11, 13'h1555, 9'h003}, 10'd8,   8,   TRCD + 3);
    reset_mid_burst();
    run_burst("after_rst", {2'b00, 13'h0001, 9'h1fe}, 10'd4, 4, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
